hms_clock_ctrl: RTL and testbench

- Controller/sequencer for the clock display datapath. It keeps the hh:mm:ss time registers and generates the 1 s tick internally.
- A 4-state mode FSM lets the user set seconds, minutes and hours with two buttons.
- Outputs are binary time fields, which feed the two-digit separators, decoders and the 6-digit scan driver.
- It also outputs a per-digit decimal-point blink mask that marks the field being edited.

---
 rtl/hms_clock_ctrl_if.sv | 22 ++
 rtl/hms_clock_ctrl.sv | 125 ++++++++++++
 tb/tb_hms_clock_ctrl.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/hms_clock_ctrl_if.sv
// Button inputs and time/mode/display outputs of the hh:mm:ss clock controller.
// The controller connects through the slave modport; the driving side uses master.
interface hms_clock_ctrl_if;
  logic       i_btn_mode;
  logic       i_btn_inc;
  logic [5:0] o_sec;
  logic [5:0] o_min;
  logic [4:0] o_hour;
  logic [1:0] o_mode;
  logic       o_tick;
  logic [5:0] o_six_dp;

  modport master (
    output i_btn_mode, i_btn_inc,
    input  o_sec, o_min, o_hour, o_mode, o_tick, o_six_dp
  );

  modport slave (
    input  i_btn_mode, i_btn_inc,
    output o_sec, o_min, o_hour, o_mode, o_tick, o_six_dp
  );
endinterface

// File: rtl/hms_clock_ctrl.sv
// hh:mm:ss timekeeper with an internal 1 s tick, a 4-state set-mode FSM
// driven by two buttons, and a decimal-point blink mask marking the edited field.
module hms_clock_ctrl #(
  parameter int unsigned P_TICK_DIV = 50000000
) (
  input logic             clk,
  input logic             rst_n,
  hms_clock_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    CLOCK    = 2'd0,
    SET_SEC  = 2'd1,
    SET_MIN  = 2'd2,
    SET_HOUR = 2'd3
  } mode_e;

  localparam logic [31:0] TICK_LAST = 32'(P_TICK_DIV - 1);
  localparam logic [31:0] TICK_HALF = 32'(P_TICK_DIV / 2);

  mode_e       mode_q, mode_d;
  logic [31:0] tick_cnt_q, tick_cnt_d;
  logic        tick_q, tick_d;
  logic [5:0]  sec_q, sec_d;
  logic [5:0]  min_q, min_d;
  logic [4:0]  hour_q, hour_d;
  logic [5:0]  six_dp_q, six_dp_d;
  logic        btn_mode_q, btn_mode_d;
  logic        btn_inc_q, btn_inc_d;

  logic        mode_press;
  logic        inc_press;
  logic        blink;

  always_comb begin
    btn_mode_d = bus.i_btn_mode;
    btn_inc_d  = bus.i_btn_inc;
    mode_press = bus.i_btn_mode & ~btn_mode_q;
    inc_press  = bus.i_btn_inc & ~btn_inc_q;
    blink      = (tick_cnt_q < TICK_HALF);

    tick_cnt_d = (tick_cnt_q == TICK_LAST) ? '0 : tick_cnt_q + 32'd1;
    tick_d     = (tick_cnt_q == TICK_LAST);
    mode_d     = mode_q;
    sec_d      = sec_q;
    min_d      = min_q;
    hour_d     = hour_q;

    unique case (mode_q)
      CLOCK: begin
        // Carry chain: only the field that wraps passes the increment upward.
        if (tick_q) begin
          if (sec_q == 6'd59) begin
            sec_d = '0;
            if (min_q == 6'd59) begin
              min_d  = '0;
              hour_d = (hour_q == 5'd23) ? '0 : hour_q + 5'd1;
            end else begin
              min_d = min_q + 6'd1;
            end
          end else begin
            sec_d = sec_q + 6'd1;
          end
        end
        if (mode_press) mode_d = SET_SEC;
      end
      SET_SEC: begin
        if (inc_press) sec_d = (sec_q == 6'd59) ? '0 : sec_q + 6'd1;
        if (mode_press) mode_d = SET_MIN;
      end
      SET_MIN: begin
        if (inc_press) min_d = (min_q == 6'd59) ? '0 : min_q + 6'd1;
        if (mode_press) mode_d = SET_HOUR;
      end
      SET_HOUR: begin
        if (inc_press) hour_d = (hour_q == 5'd23) ? '0 : hour_q + 5'd1;
        // Restart the second so the first increment after setting is a full period away.
        if (mode_press) begin
          mode_d     = CLOCK;
          tick_cnt_d = '0;
        end
      end
      default: mode_d = CLOCK;
    endcase

    unique case (mode_q)
      SET_SEC:  six_dp_d = {4'b0000, blink, blink};
      SET_MIN:  six_dp_d = {2'b00, blink, blink, 2'b00};
      SET_HOUR: six_dp_d = {blink, blink, 4'b0000};
      default:  six_dp_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q     <= CLOCK;
      tick_cnt_q <= '0;
      tick_q     <= 1'b0;
      sec_q      <= '0;
      min_q      <= '0;
      hour_q     <= '0;
      six_dp_q   <= '0;
      btn_mode_q <= 1'b0;
      btn_inc_q  <= 1'b0;
    end else begin
      mode_q     <= mode_d;
      tick_cnt_q <= tick_cnt_d;
      tick_q     <= tick_d;
      sec_q      <= sec_d;
      min_q      <= min_d;
      hour_q     <= hour_d;
      six_dp_q   <= six_dp_d;
      btn_mode_q <= btn_mode_d;
      btn_inc_q  <= btn_inc_d;
    end
  end

  assign bus.o_sec    = sec_q;
  assign bus.o_min    = min_q;
  assign bus.o_hour   = hour_q;
  assign bus.o_mode   = mode_q;
  assign bus.o_tick   = tick_q;
  assign bus.o_six_dp = six_dp_q;

endmodule

// File: tb/tb_hms_clock_ctrl.sv
// Scoreboard bench for hms_clock_ctrl: a behavioural time/mode model queues
// expected snapshots as stimulus is applied; they are compared once the DUT has responded.
module tb_hms_clock_ctrl;
  localparam int unsigned DIV = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  hms_clock_ctrl_if bus ();

  hms_clock_ctrl #(.P_TICK_DIV(DIV)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  typedef struct packed {
    logic [5:0] sec;
    logic [5:0] min;
    logic [4:0] hour;
    logic [1:0] mode;
  } snap_t;
  snap_t sb[$];

  int m_sec = 0, m_min = 0, m_hour = 0, m_mode = 0;

  task automatic expect_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  task automatic push_exp();
    snap_t s;
    s.sec  = 6'(m_sec);
    s.min  = 6'(m_min);
    s.hour = 5'(m_hour);
    s.mode = 2'(m_mode);
    sb.push_back(s);
  endtask

  task automatic pop_check(input string tag);
    snap_t s;
    if (sb.size() == 0) begin
      expect_eq({tag, ".sb_empty"}, 32'd0, 32'd1);
      return;
    end
    s = sb.pop_front();
    expect_eq({tag, ".sec"},  32'(bus.o_sec),  32'(s.sec));
    expect_eq({tag, ".min"},  32'(bus.o_min),  32'(s.min));
    expect_eq({tag, ".hour"}, 32'(bus.o_hour), 32'(s.hour));
    expect_eq({tag, ".mode"}, 32'(bus.o_mode), 32'(s.mode));
  endtask

  task automatic model_tick();
    if (m_mode == 0) begin
      if (m_sec == 59) begin
        m_sec = 0;
        if (m_min == 59) begin
          m_min  = 0;
          m_hour = (m_hour == 23) ? 0 : m_hour + 1;
        end else m_min++;
      end else m_sec++;
    end
  endtask

  task automatic model_inc();
    case (m_mode)
      1: m_sec  = (m_sec + 1) % 60;
      2: m_min  = (m_min + 1) % 60;
      3: m_hour = (m_hour + 1) % 24;
      default: ;
    endcase
  endtask

  task automatic model_reset();
    m_sec = 0; m_min = 0; m_hour = 0; m_mode = 0;
  endtask

  // Waits for o_tick (bounded); optionally presses mode on that same cycle.
  task automatic wait_tick(input bit with_mode, output int unsigned det_cyc);
    bit seen = 1'b0;
    det_cyc = cyc;
    for (int i = 0; i < 3 * DIV && !seen; i++) begin
      @(negedge clk);
      if (bus.o_tick) seen = 1'b1;
    end
    if (!seen) begin
      expect_eq("tick_timeout", 32'd0, 32'd1);
      return;
    end
    det_cyc = cyc;
    if (with_mode) bus.i_btn_mode = 1'b1;
    @(negedge clk);
    bus.i_btn_mode = 1'b0;
    model_tick();
    if (with_mode) begin
      m_mode = (m_mode + 1) % 4;
      @(negedge clk);
    end
  endtask

  task automatic press_mode(output int unsigned pc);
    bus.i_btn_mode = 1'b1;
    @(negedge clk);
    pc = cyc;
    bus.i_btn_mode = 1'b0;
    @(negedge clk);
    m_mode = (m_mode + 1) % 4;
  endtask

  task automatic press_inc();
    bus.i_btn_inc = 1'b1;
    @(negedge clk);
    bus.i_btn_inc = 1'b0;
    @(negedge clk);
    model_inc();
  endtask

  task automatic set_field(input int target);
    for (int n = 0; n < 70; n++) begin
      if ((m_mode == 1 && m_sec == target) || (m_mode == 2 && m_min == target) ||
          (m_mode == 3 && m_hour == target)) break;
      press_inc();
    end
  endtask

  task automatic dp_check(input string tag, input logic [5:0] mask);
    logic [5:0] s [16];
    int bad = 0;
    int tg = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      s[i] = bus.o_six_dp;
      if (s[i] !== mask && s[i] !== 6'b000000) bad++;
      if (i > 0 && s[i] !== s[i-1]) tg++;
    end
    expect_eq({tag, ".invalid"}, 32'(bad), 32'd0);
    expect_eq({tag, ".toggles"}, 32'(tg), 32'd3);
    expect_eq({tag, ".half"}, 32'(s[0] !== s[5]), 32'd1);
  endtask

  initial begin
    int unsigned t0, t1, pc;
    bus.i_btn_mode = 1'b0;
    bus.i_btn_inc  = 1'b0;
    model_reset();

    repeat (3) @(negedge clk);
    push_exp();
    pop_check("reset");
    expect_eq("reset.tick", 32'(bus.o_tick), 32'd0);
    expect_eq("reset.dp", 32'(bus.o_six_dp), 32'd0);
    rst_n = 1'b1;

    wait_tick(1'b0, t0);
    wait_tick(1'b0, t1);
    expect_eq("tick_period", t1 - t0, DIV);
    for (int i = 0; i < 59; i++) wait_tick(1'b0, t1);
    push_exp();
    pop_check("run61");
    expect_eq("run61.dp", 32'(bus.o_six_dp), 32'd0);

    wait_tick(1'b0, t1);
    repeat (3) press_inc();
    push_exp();
    pop_check("clock_inc_ignored");

    press_mode(pc);
    push_exp();
    pop_check("mode_sec");
    dp_check("dp_sec", 6'b000011);
    set_field(58);
    push_exp();
    pop_check("sec58");
    repeat (2) press_inc();
    push_exp();
    pop_check("sec_wrap");
    set_field(58);

    bus.i_btn_mode = 1'b1;
    repeat (50) @(negedge clk);
    bus.i_btn_mode = 1'b0;
    @(negedge clk);
    m_mode = (m_mode + 1) % 4;
    push_exp();
    pop_check("mode_held");
    dp_check("dp_min", 6'b001100);
    set_field(59);

    press_mode(pc);
    push_exp();
    pop_check("mode_hour");
    dp_check("dp_hour", 6'b110000);
    set_field(23);
    press_inc();
    push_exp();
    pop_check("hour_wrap");
    set_field(23);

    press_mode(pc);
    push_exp();
    pop_check("mode_clock");
    expect_eq("clock.dp", 32'(bus.o_six_dp), 32'd0);
    wait_tick(1'b0, t1);
    expect_eq("first_tick_after_set", t1 - pc, DIV);
    push_exp();
    pop_check("t235959");
    wait_tick(1'b0, t1);
    push_exp();
    pop_check("rollover");

    for (int i = 0; i < 10 && m_sec != 5; i++) wait_tick(1'b0, t1);
    wait_tick(1'b1, t1);
    push_exp();
    pop_check("mode_plus_tick");

    press_mode(pc);
    set_field(7);
    bus.i_btn_mode = 1'b1;
    bus.i_btn_inc  = 1'b1;
    @(negedge clk);
    bus.i_btn_mode = 1'b0;
    bus.i_btn_inc  = 1'b0;
    @(negedge clk);
    model_inc();
    m_mode = (m_mode + 1) % 4;
    push_exp();
    pop_check("mode_plus_inc");

    set_field(12);
    push_exp();
    pop_check("hour12");

    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    push_exp();
    pop_check("async_rst");
    expect_eq("async_rst.dp", 32'(bus.o_six_dp), 32'd0);
    expect_eq("async_rst.tick", 32'(bus.o_tick), 32'd0);

    @(negedge clk);
    rst_n = 1'b1;
    wait_tick(1'b0, t1);
    push_exp();
    pop_check("resume");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
